// File: rtl/qpu_exu_oitf.sv
// Outstanding instruction track FIFO: one record per in-flight long-pipe instruction,
// retired in order, with combinational RAW/WAW/qubit-flag hazard lookup for dispatch.

module qpu_exu_oitf_ent #(
    parameter int RFIDX_W   = 5,
    parameter int QUBIT_NUM = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wr_en,
    input  logic                 clr_en,
    input  logic                 wr_rdwen,
    input  logic [RFIDX_W-1:0]   wr_rdidx,
    input  logic                 wr_qfren,
    input  logic [QUBIT_NUM-1:0] wr_qubitlist,
    input  logic                 disp_rs1en,
    input  logic                 disp_rs2en,
    input  logic [RFIDX_W-1:0]   disp_rs1idx,
    input  logic [RFIDX_W-1:0]   disp_rs2idx,
    input  logic                 disp_rdwen,
    input  logic [RFIDX_W-1:0]   disp_rdidx,
    input  logic                 disp_qlren,
    input  logic [QUBIT_NUM-1:0] disp_qubitlist,
    output logic                 rdwen,
    output logic [RFIDX_W-1:0]   rdidx,
    output logic                 qfren,
    output logic [QUBIT_NUM-1:0] qubitlist,
    output logic                 m_rs1,
    output logic                 m_rs2,
    output logic                 m_rd,
    output logic                 m_ql
);
    logic vld;

    // Allocate and retire never target the same slot in one cycle, so the order here is free.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            vld       <= 1'b0;
            rdwen     <= 1'b0;
            rdidx     <= '0;
            qfren     <= 1'b0;
            qubitlist <= '0;
        end else if (wr_en) begin
            vld       <= 1'b1;
            rdwen     <= wr_rdwen;
            rdidx     <= wr_rdidx;
            qfren     <= wr_qfren;
            qubitlist <= wr_qubitlist;
        end else if (clr_en) begin
            vld       <= 1'b0;
        end
    end

    assign m_rs1 = vld & rdwen & disp_rs1en & (rdidx == disp_rs1idx);
    assign m_rs2 = vld & rdwen & disp_rs2en & (rdidx == disp_rs2idx);
    assign m_rd  = vld & rdwen & disp_rdwen & (rdidx == disp_rdidx);
    assign m_ql  = vld & qfren & disp_qlren & (|(qubitlist & disp_qubitlist));
endmodule

module qpu_exu_oitf #(
    parameter int DEPTH     = 4,
    parameter int PTR_W     = 2,
    parameter int RFIDX_W   = 5,
    parameter int QUBIT_NUM = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 dis_ena,
    output logic                 dis_ready,
    input  logic                 dis_rdwen,
    input  logic [RFIDX_W-1:0]   dis_rdidx,
    input  logic                 dis_qfren,
    input  logic [QUBIT_NUM-1:0] dis_qubitlist,
    output logic [PTR_W-1:0]     dis_ptr,
    input  logic                 disp_rs1en,
    input  logic                 disp_rs2en,
    input  logic [RFIDX_W-1:0]   disp_rs1idx,
    input  logic [RFIDX_W-1:0]   disp_rs2idx,
    input  logic                 disp_rdwen,
    input  logic [RFIDX_W-1:0]   disp_rdidx,
    input  logic                 disp_qlren,
    input  logic [QUBIT_NUM-1:0] disp_qubitlist,
    output logic                 oitfrd_match_disprs1,
    output logic                 oitfrd_match_disprs2,
    output logic                 oitfrd_match_disprd,
    output logic                 oitfqf_match_dispql,
    input  logic                 ret_ena,
    output logic [PTR_W-1:0]     ret_ptr,
    output logic                 ret_rdwen,
    output logic [RFIDX_W-1:0]   ret_rdidx,
    output logic                 ret_qfren,
    output logic [QUBIT_NUM-1:0] ret_qubitlist,
    output logic                 oitf_empty
);
    localparam logic [PTR_W:0] PTR_ONE = 1;

    // MSB of each pointer is the wrap flag; a plain increment toggles it on wrap.
    logic [PTR_W:0] tail_q, head_q;
    logic           full, empty, alloc, retire;

    logic [DEPTH-1:0]                wr_sel, clr_sel;
    logic [DEPTH-1:0]                ent_rdwen, ent_qfren;
    logic [DEPTH-1:0][RFIDX_W-1:0]   ent_rdidx;
    logic [DEPTH-1:0][QUBIT_NUM-1:0] ent_qubitlist;
    logic [DEPTH-1:0]                m_rs1, m_rs2, m_rd, m_ql;

    assign full   = (tail_q[PTR_W-1:0] == head_q[PTR_W-1:0]) & (tail_q[PTR_W] != head_q[PTR_W]);
    assign empty  = (tail_q == head_q);
    assign alloc  = dis_ena & ~full;
    assign retire = ret_ena & ~empty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tail_q <= '0;
            head_q <= '0;
        end else begin
            if (alloc)  tail_q <= tail_q + PTR_ONE;
            if (retire) head_q <= head_q + PTR_ONE;
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_ent
        assign wr_sel[i]  = alloc  & (tail_q[PTR_W-1:0] == PTR_W'(i));
        assign clr_sel[i] = retire & (head_q[PTR_W-1:0] == PTR_W'(i));

        qpu_exu_oitf_ent #(.RFIDX_W(RFIDX_W), .QUBIT_NUM(QUBIT_NUM)) u_ent (
            .clk            (clk),
            .rst_n          (rst_n),
            .wr_en          (wr_sel[i]),
            .clr_en         (clr_sel[i]),
            .wr_rdwen       (dis_rdwen),
            .wr_rdidx       (dis_rdidx),
            .wr_qfren       (dis_qfren),
            .wr_qubitlist   (dis_qubitlist),
            .disp_rs1en     (disp_rs1en),
            .disp_rs2en     (disp_rs2en),
            .disp_rs1idx    (disp_rs1idx),
            .disp_rs2idx    (disp_rs2idx),
            .disp_rdwen     (disp_rdwen),
            .disp_rdidx     (disp_rdidx),
            .disp_qlren     (disp_qlren),
            .disp_qubitlist (disp_qubitlist),
            .rdwen          (ent_rdwen[i]),
            .rdidx          (ent_rdidx[i]),
            .qfren          (ent_qfren[i]),
            .qubitlist      (ent_qubitlist[i]),
            .m_rs1          (m_rs1[i]),
            .m_rs2          (m_rs2[i]),
            .m_rd           (m_rd[i]),
            .m_ql           (m_ql[i])
        );
    end

    assign dis_ready  = ~full;
    assign oitf_empty = empty;
    assign dis_ptr    = tail_q[PTR_W-1:0];
    assign ret_ptr    = head_q[PTR_W-1:0];

    assign ret_rdwen     = ent_rdwen[ret_ptr];
    assign ret_rdidx     = ent_rdidx[ret_ptr];
    assign ret_qfren     = ent_qfren[ret_ptr];
    assign ret_qubitlist = ent_qubitlist[ret_ptr];

    assign oitfrd_match_disprs1 = |m_rs1;
    assign oitfrd_match_disprs2 = |m_rs2;
    assign oitfrd_match_disprd  = |m_rd;
    assign oitfqf_match_dispql  = |m_ql;
endmodule

// File: tb/tb_qpu_exu_oitf.sv
// Bench for qpu_exu_oitf: queue-based scoreboard of outstanding entries, directed
// scenarios followed by a random allocate/retire/lookup phase.

module tb_qpu_exu_oitf;
    localparam int DEPTH = 4, PTR_W = 2, RFIDX_W = 5, QUBIT_NUM = 12;

    logic                 clk = 1'b0;
    logic                 rst_n;
    logic                 dis_ena, dis_ready, dis_rdwen, dis_qfren;
    logic [RFIDX_W-1:0]   dis_rdidx;
    logic [QUBIT_NUM-1:0] dis_qubitlist;
    logic [PTR_W-1:0]     dis_ptr, ret_ptr;
    logic                 disp_rs1en, disp_rs2en, disp_rdwen, disp_qlren;
    logic [RFIDX_W-1:0]   disp_rs1idx, disp_rs2idx, disp_rdidx;
    logic [QUBIT_NUM-1:0] disp_qubitlist;
    logic                 oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd, oitfqf_match_dispql;
    logic                 ret_ena, ret_rdwen, ret_qfren, oitf_empty;
    logic [RFIDX_W-1:0]   ret_rdidx;
    logic [QUBIT_NUM-1:0] ret_qubitlist;
    logic [3:0]           mt;

    qpu_exu_oitf #(.DEPTH(DEPTH), .PTR_W(PTR_W), .RFIDX_W(RFIDX_W), .QUBIT_NUM(QUBIT_NUM)) dut (
        .clk(clk), .rst_n(rst_n),
        .dis_ena(dis_ena), .dis_ready(dis_ready), .dis_rdwen(dis_rdwen), .dis_rdidx(dis_rdidx),
        .dis_qfren(dis_qfren), .dis_qubitlist(dis_qubitlist), .dis_ptr(dis_ptr),
        .disp_rs1en(disp_rs1en), .disp_rs2en(disp_rs2en), .disp_rs1idx(disp_rs1idx),
        .disp_rs2idx(disp_rs2idx), .disp_rdwen(disp_rdwen), .disp_rdidx(disp_rdidx),
        .disp_qlren(disp_qlren), .disp_qubitlist(disp_qubitlist),
        .oitfrd_match_disprs1(oitfrd_match_disprs1), .oitfrd_match_disprs2(oitfrd_match_disprs2),
        .oitfrd_match_disprd(oitfrd_match_disprd), .oitfqf_match_dispql(oitfqf_match_dispql),
        .ret_ena(ret_ena), .ret_ptr(ret_ptr), .ret_rdwen(ret_rdwen), .ret_rdidx(ret_rdidx),
        .ret_qfren(ret_qfren), .ret_qubitlist(ret_qubitlist), .oitf_empty(oitf_empty)
    );

    always #5 clk = ~clk;
    assign mt = {oitfrd_match_disprs1, oitfrd_match_disprs2, oitfrd_match_disprd, oitfqf_match_dispql};

    typedef struct {
        logic                 rdwen;
        logic [RFIDX_W-1:0]   rdidx;
        logic                 qfren;
        logic [QUBIT_NUM-1:0] ql;
    } ent_t;

    ent_t           sb[$];
    logic [PTR_W:0] mtail, mhead;
    int             vecs = 0, errs = 0;

    function automatic logic [3:0] exp_match();
        logic [3:0] m = 4'b0;
        foreach (sb[k]) begin
            if (sb[k].rdwen && disp_rs1en && sb[k].rdidx == disp_rs1idx) m[3] = 1'b1;
            if (sb[k].rdwen && disp_rs2en && sb[k].rdidx == disp_rs2idx) m[2] = 1'b1;
            if (sb[k].rdwen && disp_rdwen && sb[k].rdidx == disp_rdidx)  m[1] = 1'b1;
            if (sb[k].qfren && disp_qlren && (sb[k].ql & disp_qubitlist) != '0) m[0] = 1'b1;
        end
        return m;
    endfunction

    // Advance one clock and mirror the edge into the scoreboard model.
    task automatic tick();
        ent_t e;
        bit   al, rt;
        @(posedge clk);
        if (!rst_n) begin
            sb.delete();
            mtail = '0;
            mhead = '0;
        end else begin
            al = dis_ena && (sb.size() < DEPTH);
            rt = ret_ena && (sb.size() > 0);
            if (rt) begin
                sb.delete(0);
                mhead = mhead + (PTR_W+1)'(1);
            end
            if (al) begin
                e.rdwen = dis_rdwen; e.rdidx = dis_rdidx; e.qfren = dis_qfren; e.ql = dis_qubitlist;
                sb.push_back(e);
                mtail = mtail + (PTR_W+1)'(1);
            end
        end
        #1;
        dis_ena = 1'b0;
        ret_ena = 1'b0;
    endtask

    task automatic set_dis(input logic rw, input logic [RFIDX_W-1:0] idx, input logic qf, input logic [QUBIT_NUM-1:0] ql);
        dis_ena = 1'b1; dis_rdwen = rw; dis_rdidx = idx; dis_qfren = qf; dis_qubitlist = ql;
    endtask

    task automatic clr_disp();
        disp_rs1en = 1'b0; disp_rs2en = 1'b0; disp_rdwen = 1'b0; disp_qlren = 1'b0;
        disp_rs1idx = '0; disp_rs2idx = '0; disp_rdidx = '0; disp_qubitlist = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; dis_ena = 1'b0; ret_ena = 1'b0;
        dis_rdwen = 1'b0; dis_rdidx = '0; dis_qfren = 1'b0; dis_qubitlist = '0;
        clr_disp();
        tick(); tick();
        rst_n = 1'b1;
        disp_rs1en = 1'b1; disp_rs2en = 1'b1; disp_rdwen = 1'b1; disp_qlren = 1'b1; disp_qubitlist = '1;
        #1;
        vecs++; if ({dis_ready, oitf_empty} !== 2'b11) begin errs++; $display("FAIL reset_flags got %b want 11", {dis_ready, oitf_empty}); end
        vecs++; if ({dis_ptr, ret_ptr} !== 4'b0) begin errs++; $display("FAIL reset_ptrs got %h want 0", {dis_ptr, ret_ptr}); end
        vecs++; if (mt !== 4'b0) begin errs++; $display("FAIL reset_matches got %b want 0000", mt); end
        vecs++; if ({ret_rdwen, ret_rdidx, ret_qfren, ret_qubitlist} !== 19'd0) begin errs++;
            $display("FAIL reset_ret_fields got %h want 0", {ret_rdwen, ret_rdidx, ret_qfren, ret_qubitlist}); end
        clr_disp();
    endtask

    task automatic test_raw_waw();
        clr_disp();
        set_dis(1'b1, 5'd5, 1'b0, '0);
        disp_rs1en = 1'b1; disp_rs1idx = 5'd5;
        #1;
        vecs++; if (mt[3] !== 1'b0) begin errs++; $display("FAIL raw_same_cycle_invisible got %b want 0", mt[3]); end
        tick();
        vecs++; if (mt !== 4'b1000) begin errs++; $display("FAIL raw_rs1_hit got %b want 1000", mt); end
        disp_rs1idx = 5'd6; #1;
        vecs++; if (mt !== 4'b0000) begin errs++; $display("FAIL raw_rs1_miss got %b want 0000", mt); end
        disp_rs2en = 1'b1; disp_rs2idx = 5'd5; disp_rdwen = 1'b1; disp_rdidx = 5'd5; #1;
        vecs++; if (mt !== 4'b0110) begin errs++; $display("FAIL raw_rs2_waw_hit got %b want 0110", mt); end
        ret_ena = 1'b1; #1;
        vecs++; if (mt !== 4'b0110) begin errs++; $display("FAIL retiring_entry_still_matches got %b want 0110", mt); end
        vecs++; if ({ret_rdwen, ret_rdidx} !== {sb[0].rdwen, sb[0].rdidx}) begin errs++;
            $display("FAIL raw_ret_head got %h want %h", {ret_rdwen, ret_rdidx}, {sb[0].rdwen, sb[0].rdidx}); end
        tick();
        vecs++; if ({oitf_empty, mt} !== 5'b10000) begin errs++; $display("FAIL raw_after_retire got %b want 10000", {oitf_empty, mt}); end
        clr_disp();
    endtask

    task automatic test_fill();
        logic [PTR_W-1:0] p0;
        clr_disp();
        p0 = dis_ptr;
        for (int k = 0; k < DEPTH; k++) begin
            vecs++; if (dis_ptr !== mtail[PTR_W-1:0]) begin errs++; $display("FAIL fill_dis_ptr%0d got %0d want %0d", k, dis_ptr, mtail[PTR_W-1:0]); end
            set_dis(1'b1, RFIDX_W'(10 + k), 1'b0, '0);
            tick();
        end
        vecs++; if ({dis_ready, oitf_empty, dis_ptr} !== {2'b00, p0}) begin errs++;
            $display("FAIL fill_full got %b want %b", {dis_ready, oitf_empty, dis_ptr}, {2'b00, p0}); end
        set_dis(1'b1, 5'd20, 1'b0, '0);
        disp_rdwen = 1'b1; disp_rdidx = 5'd20;
        tick();
        vecs++; if ({dis_ready, dis_ptr, ret_ptr, mt[1]} !== {1'b0, p0, p0, 1'b0}) begin errs++;
            $display("FAIL fill_overflow_ignored got %b want %b", {dis_ready, dis_ptr, ret_ptr, mt[1]}, {1'b0, p0, p0, 1'b0}); end
        set_dis(1'b1, 5'd21, 1'b0, '0);
        ret_ena = 1'b1; disp_rdidx = 5'd21; #1;
        vecs++; if (ret_rdidx !== sb[0].rdidx) begin errs++; $display("FAIL fill_ret_head got %0d want %0d", ret_rdidx, sb[0].rdidx); end
        tick();
        vecs++; if ({dis_ready, dis_ptr, ret_ptr, mt[1]} !== {1'b1, p0, p0 + 2'd1, 1'b0}) begin errs++;
            $display("FAIL fill_no_bypass got %b want %b", {dis_ready, dis_ptr, ret_ptr, mt[1]}, {1'b1, p0, p0 + 2'd1, 1'b0}); end
        while (sb.size() > 0) begin
            ret_ena = 1'b1; #1;
            vecs++; if ({ret_rdwen, ret_rdidx, ret_qfren, ret_qubitlist} !== {sb[0].rdwen, sb[0].rdidx, sb[0].qfren, sb[0].ql}) begin errs++;
                $display("FAIL fill_drain got %h want %h", {ret_rdwen, ret_rdidx, ret_qfren, ret_qubitlist}, {sb[0].rdwen, sb[0].rdidx, sb[0].qfren, sb[0].ql}); end
            tick();
        end
        vecs++; if (oitf_empty !== 1'b1) begin errs++; $display("FAIL fill_empty got %b want 1", oitf_empty); end
        clr_disp();
    endtask

    task automatic test_qubit();
        clr_disp();
        set_dis(1'b0, 5'd0, 1'b1, 12'h00C); tick();
        set_dis(1'b0, 5'd3, 1'b0, 12'hFFF); tick();
        disp_qlren = 1'b1; disp_qubitlist = 12'h004; #1;
        vecs++; if (mt !== 4'b0001) begin errs++; $display("FAIL qf_hit got %b want 0001", mt); end
        disp_qubitlist = 12'h003; #1;
        vecs++; if (mt !== 4'b0000) begin errs++; $display("FAIL qf_disjoint got %b want 0000", mt); end
        disp_qlren = 1'b0; disp_qubitlist = 12'h004; #1;
        vecs++; if (mt !== 4'b0000) begin errs++; $display("FAIL qf_disabled got %b want 0000", mt); end
        while (sb.size() > 0) begin
            ret_ena = 1'b1; #1;
            vecs++; if ({ret_qfren, ret_qubitlist} !== {sb[0].qfren, sb[0].ql}) begin errs++;
                $display("FAIL qf_ret got %h want %h", {ret_qfren, ret_qubitlist}, {sb[0].qfren, sb[0].ql}); end
            tick();
        end
        clr_disp();
    endtask

    task automatic test_wrap();
        clr_disp();
        set_dis(1'b1, 5'd1, 1'b0, '0); tick();
        set_dis(1'b1, 5'd2, 1'b0, '0); tick();
        for (int k = 0; k < 10; k++) begin
            set_dis(1'b1, RFIDX_W'(3 + k), 1'b0, '0);
            ret_ena = 1'b1; #1;
            vecs++; if (ret_rdidx !== RFIDX_W'(1 + k)) begin errs++; $display("FAIL wrap_order%0d got %0d want %0d", k, ret_rdidx, 1 + k); end
            vecs++; if ({dis_ready, oitf_empty, 2'(dis_ptr - ret_ptr)} !== 4'b1010) begin errs++;
                $display("FAIL wrap_occupancy%0d got %b want 1010", k, {dis_ready, oitf_empty, 2'(dis_ptr - ret_ptr)}); end
            tick();
        end
        while (sb.size() > 0) begin
            ret_ena = 1'b1; #1;
            vecs++; if (ret_rdidx !== sb[0].rdidx) begin errs++; $display("FAIL wrap_drain got %0d want %0d", ret_rdidx, sb[0].rdidx); end
            tick();
        end
    endtask

    task automatic test_mid_reset();
        clr_disp();
        set_dis(1'b1, 5'd7, 1'b0, '0);     tick();
        set_dis(1'b1, 5'd8, 1'b1, 12'h0F0); tick();
        set_dis(1'b1, 5'd9, 1'b0, '0);     tick();
        set_dis(1'b1, 5'd15, 1'b0, '0);
        ret_ena = 1'b1; rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        disp_rs1en = 1'b1; disp_rs1idx = 5'd7; disp_rdwen = 1'b1; disp_rdidx = 5'd15;
        disp_qlren = 1'b1; disp_qubitlist = 12'h0F0; #1;
        vecs++; if ({dis_ready, oitf_empty, dis_ptr, ret_ptr} !== 6'b110000) begin errs++;
            $display("FAIL midrst_state got %b want 110000", {dis_ready, oitf_empty, dis_ptr, ret_ptr}); end
        vecs++; if (mt !== 4'b0) begin errs++; $display("FAIL midrst_matches got %b want 0000", mt); end
        ret_ena = 1'b1;
        tick();
        vecs++; if ({oitf_empty, dis_ptr, ret_ptr} !== 5'b10000) begin errs++;
            $display("FAIL midrst_underflow got %b want 10000", {oitf_empty, dis_ptr, ret_ptr}); end
        set_dis(1'b1, 5'd9, 1'b0, '0); tick();
        vecs++; if ({dis_ptr, ret_ptr, ret_rdidx} !== {2'd1, 2'd0, 5'd9}) begin errs++;
            $display("FAIL midrst_realloc got %h want %h", {dis_ptr, ret_ptr, ret_rdidx}, {2'd1, 2'd0, 5'd9}); end
        ret_ena = 1'b1; tick();
        clr_disp();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            if (sb.size() < DEPTH && $urandom_range(0, 2) != 0)
                set_dis(1'($urandom), RFIDX_W'($urandom_range(0, 7)), 1'($urandom), QUBIT_NUM'($urandom));
            ret_ena = ($urandom_range(0, 2) == 0);
            disp_rs1en = 1'($urandom); disp_rs1idx = RFIDX_W'($urandom_range(0, 7));
            disp_rs2en = 1'($urandom); disp_rs2idx = RFIDX_W'($urandom_range(0, 7));
            disp_rdwen = 1'($urandom); disp_rdidx = RFIDX_W'($urandom_range(0, 7));
            disp_qlren = 1'($urandom); disp_qubitlist = QUBIT_NUM'($urandom) & QUBIT_NUM'($urandom);
            #1;
            vecs++; if (mt !== exp_match()) begin errs++; $display("FAIL rand_match%0d got %b want %b", c, mt, exp_match()); end
            vecs++; if ({dis_ready, oitf_empty, dis_ptr, ret_ptr} !== {sb.size() < DEPTH, sb.size() == 0, mtail[PTR_W-1:0], mhead[PTR_W-1:0]}) begin errs++;
                $display("FAIL rand_state%0d got %b want %b", c, {dis_ready, oitf_empty, dis_ptr, ret_ptr},
                         {sb.size() < DEPTH, sb.size() == 0, mtail[PTR_W-1:0], mhead[PTR_W-1:0]}); end
            if (sb.size() > 0) begin
                vecs++; if ({ret_rdwen, ret_rdidx, ret_qfren, ret_qubitlist} !== {sb[0].rdwen, sb[0].rdidx, sb[0].qfren, sb[0].ql}) begin errs++;
                    $display("FAIL rand_head%0d got %h want %h", c, {ret_rdwen, ret_rdidx, ret_qfren, ret_qubitlist}, {sb[0].rdwen, sb[0].rdidx, sb[0].qfren, sb[0].ql}); end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_raw_waw();
        test_fill();
        test_qubit();
        test_wrap();
        test_mid_reset();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule
